ip_uart_rx: RTL and testbench
=============================

Name: ip_uart_rx

Overview:
- Asynchronous serial receiver, 8N1 format, LSB first. It is the receive-side counterpart of ip_uart, the UART transmitter.
- Oversamples the serial input with the system clock and validates the start bit at mid-bit.
- Samples the data and stop bits at their bit centres and presents each received byte through a single-entry holding register with a valid/ack handshake.
- Intended for host-to-cartridge debug and command input alongside ip_uart in tangcart_msx.

Parameters:
- clk_freq, 54000000: clk frequency in Hz.
- uart_freq, 115200: baud rate in Hz.
- Derived constant div = clk_freq / uart_freq (integer division). Requires div >= 4.
- Derived constant half = div / 2 (integer division).
- Derived counter width = $clog2(div).

Ports:
- clk, input, 1: system clock.
- n_reset, input, 1: asynchronous, active-low reset.
- uart_rx, input, 1: serial line. Idle level is high.
- recv_data, output, 8: last received byte.
- recv_valid, output, 1: recv_data holds an unconsumed byte.
- recv_ack, input, 1: consumer takes the byte. Sampled while recv_valid=1; ignored while recv_valid=0.
- frame_error, output, 1: one-clock pulse when a stop bit is sampled low.
- overrun_error, output, 1: one-clock pulse when a byte arrives while the previous byte is unconsumed.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset: all registers clear asynchronously on n_reset=0.
  - State = IDLE; counters = 0; synchronizer flops = 1.
  - recv_data = 8'h00; recv_valid = 0; frame_error = 0; overrun_error = 0; busy = 0.
- Input path: two-flop synchronizer produces rx_s. The FSM uses rx_s only.
- Reference point T0: the first clk cycle in which the FSM is in IDLE and rx_s = 0. With an edge aligned to clk, T0 = falling edge of uart_rx + 2 cycles.
- State IDLE: on rx_s = 0, load bit counter with half-1 and go to START.
- State START: count down to 0. At T0+half, sample rx_s:
  - rx_s = 0: load div-1, clear bit index, go to DATA.
  - rx_s = 1: glitch. Return to IDLE; no flags raised.
- State DATA: sample bit n at T0+half+(n+1)*div, for n = 0..7.
  - Shift in from the MSB side so that the first bit received ends up in bit 0.
  - After bit 7, reload div-1 and go to STOP.
- State STOP: sample at T0+half+9*div.
  - rx_s = 1: deliver the byte; go to IDLE.
  - rx_s = 0: frame_error pulses in the next cycle; the byte is discarded and recv_valid is unchanged. Go to BREAK.
- State BREAK: wait until rx_s = 1, then go to IDLE. A line held low therefore produces exactly one frame_error.
- Delivery: at cycle T0+half+9*div+1, recv_data = byte and recv_valid = 1.
- Handshake:
  - recv_valid stays high and recv_data stays stable until recv_ack=1 is sampled while recv_valid=1.
  - recv_valid drops in the following cycle.
  - recv_data keeps its value after the ack.
- Simultaneous ack and delivery in the same cycle: the new byte is loaded, recv_valid stays 1, and no overrun is flagged.
- Overrun: a delivery while recv_valid=1 and recv_ack=0 overwrites recv_data with the new byte, keeps recv_valid=1, and pulses overrun_error for one cycle.
- Back-to-back frames: after STOP the FSM is in IDLE half a bit before the nominal stop-bit end, so a start edge arriving immediately after the stop bit is accepted.
- Reset mid-frame returns all state to the reset values immediately. The partially received byte is lost. Because a low line reads as a start, the FSM may resynchronise on a later start edge.
- Counter arithmetic: all counters are unsigned and count down. There is no wrap-around: every counter is reloaded at zero.

Test Plan (clk_freq=1000000, uart_freq=100000, so div=10, half=5; edge aligned to clk at cycle 0):
- Send 8'hA5, 8N1, recv_ack held 0 -> recv_valid rises at cycle 98 with recv_data=8'hA5; frame_error and overrun_error stay 0; busy falls to 0 by cycle 98.
- 3-cycle low glitch on uart_rx -> FSM returns to IDLE; recv_valid, frame_error and overrun_error remain 0; busy is high for 5 cycles only.
- Send 8'h3C with the stop bit forced 0, then hold the line low for 200 cycles and release -> one frame_error pulse at cycle 98, recv_valid stays 0. A following valid frame 8'h01 is delivered correctly.
- Send 8'h11 then 8'h22 back-to-back, never ack -> recv_data=8'h22 after the second frame, recv_valid=1, one overrun_error pulse at the second delivery.
- Send 8'h11, with recv_ack=1 asserted exactly at the second frame's delivery cycle -> recv_data=8'h22, recv_valid=1, no overrun_error.
- Assert n_reset=0 at cycle 50 of a frame for 3 cycles -> all outputs at reset values immediately, no recv_valid. A subsequent frame 8'hFF received after the line is idle is delivered as 8'hFF.

Source files
------------

// File: rtl/ip_uart_rx.sv
// ip_uart_rx: 8N1 oversampling UART receiver with single-entry valid/ack holding register
module ip_uart_rx #(
  parameter int clk_freq  = 54000000,
  parameter int uart_freq = 115200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       uart_rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  input  logic       recv_ack,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       busy
);
  localparam int div  = clk_freq / uart_freq;
  localparam int half = div / 2;
  localparam int cw   = $clog2(div);
  localparam logic [cw-1:0] half_m1 = cw'(half - 1);
  localparam logic [cw-1:0] div_m1  = cw'(div - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic s1, rx_s, deliver, ferr, zero;
  assign zero = cnt == '0;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n = sh;
    deliver = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        cnt_n = half_m1;
        state_n = START;
      end
      START: if (!zero) cnt_n = cnt - 1'b1;
        else if (!rx_s) begin
          cnt_n = div_m1;
          idx_n = '0;
          state_n = DATA;
        end else state_n = IDLE;
      DATA: if (!zero) cnt_n = cnt - 1'b1;
        else begin
          sh_n = {rx_s, sh[7:1]};
          cnt_n = div_m1;
          idx_n = idx + 3'd1;
          state_n = idx == 3'd7 ? STOP : DATA;
        end
      STOP: if (!zero) cnt_n = cnt - 1'b1;
        else begin
          deliver = rx_s;
          ferr = !rx_s;
          state_n = rx_s ? IDLE : BREAK;
        end
      BREAK: state_n = rx_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      s1 <= 1'b1;
      rx_s <= 1'b1;
      recv_data <= '0;
      recv_valid <= 1'b0;
      frame_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      s1 <= uart_rx;
      rx_s <= s1;
      recv_data <= deliver ? sh : recv_data;
      // a delivery coinciding with an ack replaces the byte without flagging overrun
      recv_valid <= deliver | (recv_valid & ~recv_ack);
      frame_error <= ferr;
      overrun_error <= deliver & recv_valid & ~recv_ack;
    end
endmodule

// File: tb/tb_ip_uart_rx.sv
// tb_ip_uart_rx: directed self-checking bench for ip_uart_rx at div=10, half=5
module tb_ip_uart_rx;
  logic clk = 1'b0, n_reset = 1'b0, uart_rx = 1'b1, recv_ack = 1'b0;
  logic [7:0] recv_data;
  logic recv_valid, frame_error, overrun_error, busy;
  int cyc = 0, t0 = 0, n_tests = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, bsy_cnt = 0, fe_cyc = -1, ov_cyc = -1, rv_cyc = -1;
  logic rv_q = 1'b0;

  ip_uart_rx #(.clk_freq(1000000), .uart_freq(100000)) dut (
    .clk(clk), .n_reset(n_reset), .uart_rx(uart_rx), .recv_data(recv_data),
    .recv_valid(recv_valid), .recv_ack(recv_ack), .frame_error(frame_error),
    .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_error) begin fe_cnt++; fe_cyc = cyc; end
    if (overrun_error) begin ov_cnt++; ov_cyc = cyc; end
    if (busy) bsy_cnt++;
    if (recv_valid && !rv_q) rv_cyc = cyc;
    rv_q = recv_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    fe_cnt = 0; ov_cnt = 0; bsy_cnt = 0; fe_cyc = -1; ov_cyc = -1; rv_cyc = -1;
  endtask

  // called just after a posedge; the start edge lands at cycle t0
  task automatic send(input logic [7:0] b, input logic stop);
    t0 = cyc;
    uart_rx = 1'b0;
    for (int i = 0; i < 9; i++) begin
      repeat (10) @(posedge clk);
      #1 uart_rx = i < 8 ? b[i] : stop;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    recv_ack = 1'b1;
    @(posedge clk);
    #1 recv_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", recv_data, 8'h00);
    check("rst_valid", recv_valid, 0);
    check("rst_fe", frame_error, 0);
    check("rst_ov", overrun_error, 0);
    check("rst_busy", busy, 0);
    n_reset = 1'b1;
    idle(5);

    clear_stats();
    send(8'hA5, 1'b1);
    check("a5_rise_cycle", rv_cyc - t0, 98);
    check("a5_data", recv_data, 8'hA5);
    check("a5_valid", recv_valid, 1);
    check("a5_fe", fe_cnt, 0);
    check("a5_ov", ov_cnt, 0);
    check("a5_busy", busy, 0);
    idle(5);
    check("a5_hold_valid", recv_valid, 1);
    ack();
    check("ack_valid", recv_valid, 0);
    check("ack_data", recv_data, 8'hA5);

    idle(10);
    clear_stats();
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 idle(20);
    check("glitch_busy_cycles", bsy_cnt, 5);
    check("glitch_valid", recv_valid, 0);
    check("glitch_fe", fe_cnt, 0);
    check("glitch_ov", ov_cnt, 0);

    clear_stats();
    send(8'h3C, 1'b0);
    uart_rx = 1'b0;
    repeat (200) @(posedge clk);
    #1 check("brk_busy", busy, 1);
    idle(20);
    check("fe_cycle", fe_cyc - t0, 98);
    check("fe_count", fe_cnt, 1);
    check("fe_valid", recv_valid, 0);
    check("fe_busy", busy, 0);
    send(8'h01, 1'b1);
    check("post_fe_data", recv_data, 8'h01);
    check("post_fe_valid", recv_valid, 1);
    check("post_fe_count", fe_cnt, 1);
    ack();
    idle(10);

    clear_stats();
    send(8'h11, 1'b1);
    check("b2b_first", recv_data, 8'h11);
    send(8'h22, 1'b1);
    check("ovr_data", recv_data, 8'h22);
    check("ovr_valid", recv_valid, 1);
    check("ovr_count", ov_cnt, 1);
    check("ovr_cycle", ov_cyc - t0, 98);
    ack();
    idle(10);

    clear_stats();
    send(8'h11, 1'b1);
    fork
      send(8'h22, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1 ack();
      end
    join
    check("sim_ack_data", recv_data, 8'h22);
    check("sim_ack_valid", recv_valid, 1);
    check("sim_ack_ov", ov_cnt, 0);
    ack();
    idle(10);

    clear_stats();
    fork
      send(8'hF0, 1'b1);
      begin
        repeat (50) @(posedge clk);
        #1 n_reset = 1'b0;
        #1;
        check("mid_rst_data", recv_data, 8'h00);
        check("mid_rst_valid", recv_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fe", frame_error, 0);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
      end
    join
    idle(20);
    check("after_rst_valid", recv_valid, 0);
    check("after_rst_fe", fe_cnt, 0);
    send(8'hFF, 1'b1);
    check("ff_data", recv_data, 8'hFF);
    check("ff_valid", recv_valid, 1);
    check("ff_rise_cycle", rv_cyc - t0, 98);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
